// File: rtl/dma_chunk_sequencer.sv
// Splits one programmed DMA transfer into buffer-sized chunks and issues a
// read command then a write command per chunk to the AHB master.
module dma_chunk_sequencer #(
    parameter int BUFFER_SIZE = 4,
    parameter int LW          = $clog2(4*BUFFER_SIZE)+1
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          cfg_start_i,
    input  logic [31:0]   cfg_src_addr_i,
    input  logic [31:0]   cfg_dst_addr_i,
    input  logic [15:0]   cfg_length_i,
    input  logic [1:0]    cfg_size_i,
    input  logic          cfg_src_incr_i,
    input  logic          cfg_dst_incr_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    output logic          m_valid_o,
    output logic          m_mode_o,
    output logic [31:0]   m_rd_addr_o,
    output logic [31:0]   m_wr_addr_o,
    output logic [LW-1:0] m_length_o,
    output logic [1:0]    m_size_o,
    output logic          m_incr_o,
    output logic          m_race_o,
    output logic          m_enable_o,
    input  logic          m_next_i,
    input  logic          m_last_i,
    input  logic          m_last_write_i,
    input  logic          m_hresp_i
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

    localparam logic [15:0] CMAX = 16'(4*BUFFER_SIZE);

    state_t      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] rem_q, rem_d;
    logic [1:0]  size_q, size_d;
    logic        src_incr_q, src_incr_d;
    logic        dst_incr_q, dst_incr_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [15:0] chunk;
    logic        cfg_bad;
    logic        wr_phase;

    assign chunk   = (rem_q > CMAX) ? CMAX : rem_q;
    assign cfg_bad = (cfg_size_i == 2'd3) ||
                     (cfg_size_i == 2'd1 && cfg_length_i[0]) ||
                     (cfg_size_i == 2'd2 && (|cfg_length_i[1:0]));

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            size_q     <= '0;
            src_incr_q <= 1'b0;
            dst_incr_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            size_q     <= size_d;
            src_incr_q <= src_incr_d;
            dst_incr_q <= dst_incr_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        size_d     = size_q;
        src_incr_d = src_incr_q;
        dst_incr_d = dst_incr_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start_i) begin
                    src_d      = cfg_src_addr_i;
                    dst_d      = cfg_dst_addr_i;
                    rem_d      = cfg_length_i;
                    size_d     = cfg_size_i;
                    src_incr_d = cfg_src_incr_i;
                    dst_incr_d = cfg_dst_incr_i;
                    if (cfg_length_i == 16'd0) done_d = 1'b1;
                    else if (cfg_bad)          error_d = 1'b1;
                    else                       state_d = RD_REQ;
                end
            end
            RD_REQ:  if (m_next_i) state_d = RD_WAIT;
            RD_WAIT: if (m_last_i) state_d = WR_REQ;
            WR_REQ:  if (m_next_i) state_d = WR_WAIT;
            WR_WAIT: begin
                if (m_last_write_i) begin
                    rem_d = rem_q - chunk;
                    if (src_incr_q) src_d = src_q + 32'(chunk);
                    if (dst_incr_q) dst_d = dst_q + 32'(chunk);
                    if (rem_d == 16'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Bus error wins over any handshake seen in the same cycle.
        if (state_q != IDLE && m_hresp_i) begin
            state_d    = IDLE;
            done_d     = 1'b0;
            error_d    = 1'b1;
            src_d      = '0;
            dst_d      = '0;
            rem_d      = '0;
            size_d     = '0;
            src_incr_d = 1'b0;
            dst_incr_d = 1'b0;
        end
    end

    assign wr_phase    = (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign m_valid_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign m_mode_o    = wr_phase;
    assign m_rd_addr_o = src_q;
    assign m_wr_addr_o = dst_q;
    assign m_length_o  = chunk[LW-1:0];
    assign m_size_o    = size_q;
    assign m_incr_o    = busy_o & (wr_phase ? dst_incr_q : src_incr_q);
    assign m_race_o    = 1'b0;
    assign m_enable_o  = busy_o;

endmodule

// File: tb/tb_dma_chunk_sequencer.sv
// Directed bench for dma_chunk_sequencer: a vector table of whole transfers
// plus hand sequences for busy-start, abort and mid-transfer reset.
module tb_dma_chunk_sequencer;

    localparam int BUFFER_SIZE = 4;
    localparam int LW = $clog2(4*BUFFER_SIZE)+1;

    logic          hclk = 1'b0;
    logic          hreset = 1'b1;
    logic          cfg_start_i = 1'b0;
    logic [31:0]   cfg_src_addr_i = '0;
    logic [31:0]   cfg_dst_addr_i = '0;
    logic [15:0]   cfg_length_i = '0;
    logic [1:0]    cfg_size_i = '0;
    logic          cfg_src_incr_i = 1'b0;
    logic          cfg_dst_incr_i = 1'b0;
    logic          busy_o, done_o, error_o, m_valid_o, m_mode_o;
    logic [31:0]   m_rd_addr_o, m_wr_addr_o;
    logic [LW-1:0] m_length_o;
    logic [1:0]    m_size_o;
    logic          m_incr_o, m_race_o, m_enable_o;
    logic          m_next_i = 1'b0;
    logic          m_last_i = 1'b0;
    logic          m_last_write_i = 1'b0;
    logic          m_hresp_i = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 hclk = ~hclk;

    dma_chunk_sequencer #(.BUFFER_SIZE(BUFFER_SIZE), .LW(LW)) dut (
        .hclk(hclk), .hreset(hreset),
        .cfg_start_i(cfg_start_i), .cfg_src_addr_i(cfg_src_addr_i),
        .cfg_dst_addr_i(cfg_dst_addr_i), .cfg_length_i(cfg_length_i),
        .cfg_size_i(cfg_size_i), .cfg_src_incr_i(cfg_src_incr_i),
        .cfg_dst_incr_i(cfg_dst_incr_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .m_valid_o(m_valid_o), .m_mode_o(m_mode_o),
        .m_rd_addr_o(m_rd_addr_o), .m_wr_addr_o(m_wr_addr_o),
        .m_length_o(m_length_o), .m_size_o(m_size_o), .m_incr_o(m_incr_o),
        .m_race_o(m_race_o), .m_enable_o(m_enable_o),
        .m_next_i(m_next_i), .m_last_i(m_last_i),
        .m_last_write_i(m_last_write_i), .m_hresp_i(m_hresp_i)
    );

    typedef enum int {K_RUN, K_DONE, K_ERR} kind_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic [1:0]  size;
        logic        si;
        logic        di;
        kind_t       kind;
        int          n;
        logic [31:0] rd0;
        logic [31:0] wr0;
        logic [31:0] rstep;
        logic [31:0] wstep;
        logic [15:0] last_len;
    } vec_t;

    localparam int NV = 10;
    vec_t vt[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, input logic [1:0] sz,
                            input logic si, input logic di);
        cfg_src_addr_i = src;
        cfg_dst_addr_i = dst;
        cfg_length_i   = len;
        cfg_size_i     = sz;
        cfg_src_incr_i = si;
        cfg_dst_incr_i = di;
        cfg_start_i    = 1'b1;
        @(negedge hclk);
        cfg_start_i    = 1'b0;
    endtask

    // Entered with RD_REQ visible; returns one cycle after m_last_write_i.
    task automatic serve_chunk(input logic [31:0] rd, input logic [31:0] wr,
                               input logic [15:0] len, input logic [1:0] sz,
                               input logic si, input logic di);
        chk1("rd_valid", m_valid_o, 1'b1);
        chk1("rd_mode", m_mode_o, 1'b0);
        chk("rd_addr", m_rd_addr_o, rd);
        chk("rd_len", 32'(m_length_o), 32'(len));
        chk1("rd_incr", m_incr_o, si);
        chk("size", 32'(m_size_o), 32'(sz));
        @(negedge hclk);
        chk1("rd_hold_valid", m_valid_o, 1'b1);
        chk("rd_hold_addr", m_rd_addr_o, rd);
        m_next_i = 1'b1;
        @(negedge hclk);
        m_next_i = 1'b0;
        chk1("rd_drop", m_valid_o, 1'b0);
        chk1("rd_busy", busy_o, 1'b1);
        m_last_i = 1'b1;
        @(negedge hclk);
        m_last_i = 1'b0;
        chk1("wr_valid", m_valid_o, 1'b1);
        chk1("wr_mode", m_mode_o, 1'b1);
        chk("wr_addr", m_wr_addr_o, wr);
        chk("wr_len", 32'(m_length_o), 32'(len));
        chk1("wr_incr", m_incr_o, di);
        m_next_i = 1'b1;
        @(negedge hclk);
        m_next_i = 1'b0;
        chk1("wr_drop", m_valid_o, 1'b0);
        m_last_write_i = 1'b1;
        @(negedge hclk);
        m_last_write_i = 1'b0;
    endtask

    initial begin
        vt[0] = '{32'h100, 32'h200, 16'd8, 2'd2, 1'b1, 1'b1, K_RUN, 1, 32'h100, 32'h200, 32'd16, 32'd16, 16'd8};
        vt[1] = '{32'h1000, 32'h2000, 16'd40, 2'd2, 1'b1, 1'b1, K_RUN, 3, 32'h1000, 32'h2000, 32'd16, 32'd16, 16'd8};
        vt[2] = '{32'h1000, 32'h2000, 16'd40, 2'd2, 1'b0, 1'b1, K_RUN, 3, 32'h1000, 32'h2000, 32'd0, 32'd16, 16'd8};
        vt[3] = '{32'h100, 32'h200, 16'd0, 2'd2, 1'b1, 1'b1, K_DONE, 0, 32'h0, 32'h0, 32'd0, 32'd0, 16'd0};
        vt[4] = '{32'h100, 32'h200, 16'd6, 2'd2, 1'b1, 1'b1, K_ERR, 0, 32'h0, 32'h0, 32'd0, 32'd0, 16'd0};
        vt[5] = '{32'h100, 32'h200, 16'd8, 2'd3, 1'b1, 1'b1, K_ERR, 0, 32'h0, 32'h0, 32'd0, 32'd0, 16'd0};
        vt[6] = '{32'h100, 32'h200, 16'd3, 2'd1, 1'b1, 1'b1, K_ERR, 0, 32'h0, 32'h0, 32'd0, 32'd0, 16'd0};
        vt[7] = '{32'h10, 32'h20, 16'd4, 2'd0, 1'b1, 1'b0, K_RUN, 1, 32'h10, 32'h20, 32'd16, 32'd0, 16'd4};
        vt[8] = '{32'hFFFF_FFF8, 32'h300, 16'd32, 2'd2, 1'b1, 1'b1, K_RUN, 2, 32'hFFFF_FFF8, 32'h300, 32'd16, 32'd16, 16'd16};
        vt[9] = '{32'h500, 32'h600, 16'd18, 2'd1, 1'b1, 1'b1, K_RUN, 2, 32'h500, 32'h600, 32'd16, 32'd16, 16'd2};

        @(negedge hclk);
        @(negedge hclk);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_valid", m_valid_o, 1'b0);
        chk("rst_rd", m_rd_addr_o, 32'h0);
        hreset = 1'b0;
        @(negedge hclk);

        for (int i = 0; i < NV; i++) begin
            do_start(vt[i].src, vt[i].dst, vt[i].len, vt[i].size, vt[i].si, vt[i].di);
            if (vt[i].kind == K_DONE || vt[i].kind == K_ERR) begin
                chk1("cfg_done", done_o, vt[i].kind == K_DONE);
                chk1("cfg_err", error_o, vt[i].kind == K_ERR);
                chk1("cfg_valid", m_valid_o, 1'b0);
                chk1("cfg_busy", busy_o, 1'b0);
                @(negedge hclk);
                chk1("cfg_done_gone", done_o, 1'b0);
                chk1("cfg_err_gone", error_o, 1'b0);
                chk1("cfg_valid2", m_valid_o, 1'b0);
            end else begin
                for (int c = 0; c < vt[i].n; c++) begin
                    serve_chunk(vt[i].rd0 + 32'(c) * vt[i].rstep,
                                vt[i].wr0 + 32'(c) * vt[i].wstep,
                                (c == vt[i].n - 1) ? vt[i].last_len : 16'd16,
                                vt[i].size, vt[i].si, vt[i].di);
                    if (c < vt[i].n - 1) begin
                        chk1("mid_busy", busy_o, 1'b1);
                        chk1("mid_done", done_o, 1'b0);
                    end
                end
                chk1("end_done", done_o, 1'b1);
                chk1("end_busy", busy_o, 1'b0);
                chk1("end_valid", m_valid_o, 1'b0);
                @(negedge hclk);
                chk1("end_done_gone", done_o, 1'b0);
            end
        end

        // Start pulse while busy must not disturb the transfer in flight.
        do_start(32'h100, 32'h200, 16'd8, 2'd2, 1'b1, 1'b1);
        m_next_i = 1'b1;
        @(negedge hclk);
        m_next_i = 1'b0;
        do_start(32'h5000, 32'h6000, 16'd4, 2'd0, 1'b0, 1'b0);
        chk("busy_start_rd", m_rd_addr_o, 32'h100);
        chk("busy_start_len", 32'(m_length_o), 32'd8);
        chk1("busy_start_busy", busy_o, 1'b1);
        m_last_i = 1'b1;
        @(negedge hclk);
        m_last_i = 1'b0;
        chk("busy_start_wr", m_wr_addr_o, 32'h200);
        chk1("busy_start_mode", m_mode_o, 1'b1);
        m_next_i = 1'b1;
        @(negedge hclk);
        m_next_i = 1'b0;
        m_last_write_i = 1'b1;
        @(negedge hclk);
        m_last_write_i = 1'b0;
        chk1("busy_start_done", done_o, 1'b1);
        @(negedge hclk);

        // Abort in second chunk's RD_WAIT; hresp outranks a coincident m_last.
        do_start(32'h1000, 32'h2000, 16'd40, 2'd2, 1'b1, 1'b1);
        serve_chunk(32'h1000, 32'h2000, 16'd16, 2'd2, 1'b1, 1'b1);
        chk("abort_rd2", m_rd_addr_o, 32'h1010);
        m_next_i = 1'b1;
        @(negedge hclk);
        m_next_i = 1'b0;
        m_hresp_i = 1'b1;
        m_last_i = 1'b1;
        @(negedge hclk);
        m_hresp_i = 1'b0;
        m_last_i = 1'b0;
        chk1("abort_err", error_o, 1'b1);
        chk1("abort_busy", busy_o, 1'b0);
        chk1("abort_valid", m_valid_o, 1'b0);
        chk1("abort_done", done_o, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge hclk);
            chk1("abort_quiet_valid", m_valid_o, 1'b0);
            chk1("abort_quiet_done", done_o, 1'b0);
            chk1("abort_quiet_err", error_o, 1'b0);
        end

        // Asynchronous reset while in WR_WAIT.
        do_start(32'h700, 32'h800, 16'd8, 2'd2, 1'b1, 1'b1);
        m_next_i = 1'b1;
        @(negedge hclk);
        m_next_i = 1'b0;
        m_last_i = 1'b1;
        @(negedge hclk);
        m_last_i = 1'b0;
        m_next_i = 1'b1;
        @(negedge hclk);
        m_next_i = 1'b0;
        chk1("pre_rst_busy", busy_o, 1'b1);
        chk1("pre_rst_mode", m_mode_o, 1'b1);
        #2 hreset = 1'b1;
        #1;
        chk1("arst_busy", busy_o, 1'b0);
        chk1("arst_mode", m_mode_o, 1'b0);
        chk1("arst_enable", m_enable_o, 1'b0);
        chk1("arst_incr", m_incr_o, 1'b0);
        chk("arst_rd", m_rd_addr_o, 32'h0);
        chk("arst_wr", m_wr_addr_o, 32'h0);
        chk("arst_len", 32'(m_length_o), 32'h0);
        @(negedge hclk);
        hreset = 1'b0;
        @(negedge hclk);
        chk1("post_rst_valid", m_valid_o, 1'b0);
        do_start(32'h40, 32'h80, 16'd4, 2'd0, 1'b1, 1'b1);
        chk1("post_rst_enable", m_enable_o, 1'b1);
        serve_chunk(32'h40, 32'h80, 16'd4, 2'd0, 1'b1, 1'b1);
        chk1("post_rst_done", done_o, 1'b1);
        chk1("post_rst_race", m_race_o, 1'b0);
        @(negedge hclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
